// File: rtl/fft_n4_stream.sv
// Streaming 4-point FFT/IFFT: collects x0..x3, one registered radix-4 butterfly, drains X0..X3.
// Optional build macro FFT_N4_SCALE_EN: outputs are the full-precision results >>> 2.
module fft_n4_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         sys_clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         in_sof_i,
    input  logic                         inverse_i,
    input  logic signed [DATA_WIDTH-1:0] xn_real_i,
    input  logic signed [DATA_WIDTH-1:0] xn_imag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_sof_o,
    output logic signed [DATA_WIDTH+1:0] xk_real_o,
    output logic signed [DATA_WIDTH+1:0] xk_imag_o
);

    localparam int unsigned OW = DATA_WIDTH + 2;

    typedef logic signed [OW-1:0] acc_t;
    typedef enum logic {IN_COLLECT, IN_FULL} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_DRAIN} out_state_t;

    in_state_t  in_state, in_state_nxt;
    out_state_t out_state, out_state_nxt;

    logic [1:0]                  cnt;
    logic [1:0]                  bin_idx;
    logic                        inv_q;
    logic signed [DATA_WIDTH-1:0] buf_r [4];
    logic signed [DATA_WIDTH-1:0] buf_i [4];
    acc_t                        ob_r [4];
    acc_t                        ob_i [4];

    logic in_fire, out_fire, take, last, xfer;
    acc_t s_r [4];
    acc_t s_i [4];
    acc_t y_r [4];
    acc_t y_i [4];
    acc_t a_r, a_i, b_r, b_i;

    function automatic acc_t scale_f(input acc_t v);
`ifdef FFT_N4_SCALE_EN
        return v >>> 2;
`else
        return v;
`endif
    endfunction

    // Handshake qualifiers; a non-sof sample at counter 0 is not taken.
    always_comb begin
        in_fire  = in_valid_i & in_ready_o;
        out_fire = out_valid_o & out_ready_i;
        take     = in_fire & (in_sof_i | (cnt != 2'd0));
        last     = take & ~in_sof_i & (cnt == 2'd3);
    end

    // Next-state logic for both FSMs; a FULL buffer waits for the drain side to go idle.
    always_comb begin
        in_state_nxt  = in_state;
        out_state_nxt = out_state;
        xfer          = 1'b0;
        case (in_state)
            IN_COLLECT: begin
                if (last) begin
                    if (out_state == OUT_IDLE) xfer = 1'b1;
                    else                       in_state_nxt = IN_FULL;
                end
            end
            IN_FULL: begin
                if (out_state == OUT_IDLE) begin
                    xfer         = 1'b1;
                    in_state_nxt = IN_COLLECT;
                end
            end
        endcase
        case (out_state)
            OUT_IDLE:  if (xfer) out_state_nxt = OUT_DRAIN;
            OUT_DRAIN: if (out_fire && (bin_idx == 2'd3)) out_state_nxt = OUT_IDLE;
        endcase
    end

    // Butterfly; x3 comes straight from the input port unless the buffer was parked in FULL.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            s_r[n] = OW'(buf_r[n]);
            s_i[n] = OW'(buf_i[n]);
        end
        if (in_state == IN_FULL) begin
            s_r[3] = OW'(buf_r[3]);
            s_i[3] = OW'(buf_i[3]);
        end else begin
            s_r[3] = OW'(xn_real_i);
            s_i[3] = OW'(xn_imag_i);
        end
        a_r = s_r[0] - s_r[2];
        a_i = s_i[0] - s_i[2];
        b_r = s_r[1] - s_r[3];
        b_i = s_i[1] - s_i[3];
        y_r[0] = scale_f(s_r[0] + s_r[1] + s_r[2] + s_r[3]);
        y_i[0] = scale_f(s_i[0] + s_i[1] + s_i[2] + s_i[3]);
        y_r[2] = scale_f(s_r[0] - s_r[1] + s_r[2] - s_r[3]);
        y_i[2] = scale_f(s_i[0] - s_i[1] + s_i[2] - s_i[3]);
        if (!inv_q) begin
            y_r[1] = scale_f(a_r + b_i);
            y_i[1] = scale_f(a_i - b_r);
            y_r[3] = scale_f(a_r - b_i);
            y_i[3] = scale_f(a_i + b_r);
        end else begin
            y_r[1] = scale_f(a_r - b_i);
            y_i[1] = scale_f(a_i + b_r);
            y_r[3] = scale_f(a_r + b_i);
            y_i[3] = scale_f(a_i - b_r);
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_state    <= IN_COLLECT;
            out_state   <= OUT_IDLE;
            cnt         <= 2'd0;
            bin_idx     <= 2'd0;
            inv_q       <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            out_sof_o   <= 1'b0;
            xk_real_o   <= '0;
            xk_imag_o   <= '0;
            for (int n = 0; n < 4; n++) begin
                buf_r[n] <= '0;
                buf_i[n] <= '0;
                ob_r[n]  <= '0;
                ob_i[n]  <= '0;
            end
        end else begin
            in_state    <= in_state_nxt;
            out_state   <= out_state_nxt;
            in_ready_o  <= (in_state_nxt == IN_COLLECT);
            out_valid_o <= (out_state_nxt == OUT_DRAIN);
            if (take) begin
                if (in_sof_i) begin
                    buf_r[0] <= xn_real_i;
                    buf_i[0] <= xn_imag_i;
                    inv_q    <= inverse_i;
                    cnt      <= 2'd1;
                end else begin
                    buf_r[cnt] <= xn_real_i;
                    buf_i[cnt] <= xn_imag_i;
                    cnt        <= cnt + 2'd1;
                end
            end
            // X0 goes straight to the output registers; X1..X3 step out on each handshake.
            if (xfer) begin
                for (int k = 0; k < 4; k++) begin
                    ob_r[k] <= y_r[k];
                    ob_i[k] <= y_i[k];
                end
                xk_real_o <= y_r[0];
                xk_imag_o <= y_i[0];
                out_sof_o <= 1'b1;
                bin_idx   <= 2'd0;
            end else if (out_fire) begin
                xk_real_o <= ob_r[bin_idx + 2'd1];
                xk_imag_o <= ob_i[bin_idx + 2'd1];
                out_sof_o <= 1'b0;
                bin_idx   <= bin_idx + 2'd1;
            end
        end
    end

endmodule

// File: doc/fft_n4_stream.md
FFT_N4_STREAM -- requirements
Module: fft_n4_stream

Interface
REQ-001 DATA_WIDTH, 32, signed input component width; legal range 8..32.
REQ-002 sys_clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 in_valid_i  input  1  input sample valid.
REQ-005 in_ready_o  output  1  block can accept an input sample.
REQ-006 in_sof_i  input  1  marks a sample as x0, the first sample of a frame.
REQ-007 inverse_i  input  1  0 = forward FFT, 1 = inverse; sampled with x0.
REQ-008 xn_real_i / xn_imag_i  input  DATA_WIDTH each  signed sample components.
REQ-009 out_valid_o  output  1  output bin valid.
REQ-010 out_ready_i  input  1  downstream accepts the output bin.
REQ-011 out_sof_o  output  1  high with bin X0 of each frame.
REQ-012 xk_real_o / xk_imag_o  output  DATA_WIDTH+2 each  signed bin components.

Function
REQ-013 A sample transfers when in_valid_i and in_ready_o are both high in the same cycle; an output bin transfers when out_valid_o and out_ready_i are both high in the same cycle.
REQ-014 An input counter (0..3) collects samples x0..x3 into an input buffer; the counter wraps to 0 after x3 is taken.
REQ-015 An accepted sample with in_sof_i=1 is always stored as x0; any partial frame is discarded and the counter restarts at 1.
REQ-016 An accepted sample with in_sof_i=0 while the counter is 0 is dropped; the counter stays at 0.
REQ-017 Input side FSM: COLLECT -> FULL on x3 acceptance if output side is not IDLE; otherwise COLLECT -> COLLECT with immediate transfer; FULL -> COLLECT when output side returns to IDLE.
REQ-018 in_ready_o = 1 in COLLECT, 0 in FULL.
REQ-019 Transfer = input buffer + latched inverse_i passed through one registered radix-4 butterfly stage into the output buffer.
REQ-020 Butterfly, with a = x0 - x2, b = x1 - x3: X0 = x0+x1+x2+x3; X2 = x0-x1+x2-x3.
REQ-021 Forward: X1 = (a_r + b_i, a_i - b_r); X3 = (a_r - b_i, a_i + b_r).
REQ-022 Inverse: X1 and X3 are exchanged; no 1/N factor is applied.
REQ-023 All arithmetic is full precision, sign-extended to DATA_WIDTH+2 bits, with no overflow or saturation.
REQ-024 Output side FSM: IDLE -> DRAIN on transfer; bins are presented in order X0, X1, X2, X3.
REQ-025 The output side advances one bin per output handshake; DRAIN -> IDLE when X3 transfers.
REQ-026 out_valid_o = 1 only in DRAIN, and data is held stable while out_ready_i is low.
REQ-027 Latency: x3 accepted at cycle T with output side IDLE gives X0 on the outputs, out_valid_o=1, at T+1.
REQ-028 Simultaneous events: when X3 transfers in the same cycle that a FULL buffer is pending, the pending transfer occurs in the next cycle; there is no bubble other than this one cycle.
REQ-029 With out_ready_i held at 1 and frames input back to back, throughput is 4 samples per 5 cycles or better, and no sample is lost.

Reset
REQ-030 While rst_i is high: counter = 0, both FSMs idle (COLLECT/IDLE), in_ready_o = 1, out_valid_o = 0, out_sof_o = 0, xk_real_o = xk_imag_o = 0.
REQ-031 Reset asserted mid-frame or mid-drain discards all buffered data; the first accepted sample after release must carry in_sof_i to start a frame.

Configuration
REQ-032 FFT_N4_SCALE_EN defined: each output component = full-precision result >>> 2 (arithmetic shift, rounding toward minus infinity), sign-extended to DATA_WIDTH+2 bits.
REQ-033 FFT_N4_SCALE_EN undefined: outputs are the unscaled full-precision results; latency and handshakes are identical in both builds.

Verification (DATA_WIDTH=16, macro undefined unless stated)
REQ-034 Impulse x = (1,0,0,0), forward -> X0..X3 all (1,0); out_sof_o high only on X0; X0 output at T+1.
REQ-035 x = (0,1,0,0): forward -> X = (1,0),(0,-1),(-1,0),(0,1); inverse -> X1 = (0,1), X3 = (0,-1).
REQ-036 All four samples (-32768,-32768) -> X0 = (-131072,-131072), others 0; with FFT_N4_SCALE_EN -> X0 = (-32768,-32768).
REQ-037 Two frames back to back with out_ready_i held 0 for 10 cycles -> in_ready_o drops after the 4th sample of frame 2; both frames are output intact and in order.
REQ-038 Two samples, then an in_sof_i sample, then three more -> only the new frame is output; samples without sof at counter 0 are dropped; rst_i pulsed mid-drain -> out_valid_o = 0 immediately.
